// File: rtl/exti_sched_pkg.sv
// Shared state encoding, default parameters and width helper for the
// EXTI trigger scheduler.
package exti_sched_pkg;

   localparam int DEF_NUM_SRC     = 4;
   localparam int DEF_PULSE_CYC   = 4;
   localparam int DEF_ACK_TIMEOUT = 25000;
   localparam int DEF_HOLDOFF_CYC = 250;

   typedef logic [1:0] state_t;

   localparam state_t IDLE     = 2'd0;
   localparam state_t PULSE    = 2'd1;
   localparam state_t WAIT_ACK = 2'd2;
   localparam state_t HOLDOFF  = 2'd3;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int clog2w(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the slot after
// last_grant and returns the first requester as one-hot plus index.
module rr_arbiter
   import exti_sched_pkg::*;
#(
   parameter int  NUM_SRC = DEF_NUM_SRC,
   localparam int IDX_W   = clog2w(NUM_SRC - 1)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic               any_grant,
   output logic [NUM_SRC-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   int               pos;
   logic [IDX_W-1:0] pos_idx;
   logic             found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = 0;
      pos_idx   = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         pos     = (int'(last_grant) + k) % NUM_SRC;
         pos_idx = IDX_W'(pos);
         if (!found && req[pos_idx]) begin
            found          = 1'b1;
            grant[pos_idx] = 1'b1;
            grant_idx      = pos_idx;
         end
      end
   end

   assign any_grant = found;

endmodule

// File: rtl/exti_trig_sched.sv
// EXTI trigger scheduler: latches rising edges from several fabric sources and
// grants them round-robin onto the single MCU external-interrupt line.
module exti_trig_sched
   import exti_sched_pkg::*;
#(
   parameter int  NUM_SRC     = DEF_NUM_SRC,
   parameter int  PULSE_CYC   = DEF_PULSE_CYC,
   parameter int  ACK_TIMEOUT = DEF_ACK_TIMEOUT,
   parameter int  HOLDOFF_CYC = DEF_HOLDOFF_CYC,
   localparam int IDX_W       = clog2w(NUM_SRC - 1)
) (
   input  logic               clk25,
   input  logic               fpga_rst_n,
   input  logic [NUM_SRC-1:0] src_req,
   input  logic               mcu_ack,
   input  logic [NUM_SRC-1:0] ovf_clr,
   output logic               exti_trig,
   output logic [IDX_W-1:0]   src_id,
   output logic               busy,
   output logic [NUM_SRC-1:0] ovf,
   output logic               timeout
);

   localparam int PW = clog2w(PULSE_CYC - 1);
   localparam int AW = clog2w(ACK_TIMEOUT - 1);
   localparam int HW = clog2w(HOLDOFF_CYC);

   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
   localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF_CYC);

   logic [NUM_SRC-1:0] req_q, req_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] ovf_q, ovf_d;
   logic               ack_meta_q, ack_meta_d;
   logic               ack_sync_q, ack_sync_d;
   logic               ack_prev_q, ack_prev_d;
   state_t             state_q, state_d;
   logic [PW-1:0]      pulse_cnt_q, pulse_cnt_d;
   logic [AW-1:0]      ack_cnt_q, ack_cnt_d;
   logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
   logic               early_ack_q, early_ack_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [IDX_W-1:0]   src_id_q, src_id_d;
   logic               exti_trig_q, exti_trig_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   logic [NUM_SRC-1:0] src_edge;
   logic [NUM_SRC-1:0] grant_clr;
   logic               ack_edge;
   logic               arb_any;
   logic [NUM_SRC-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;

   rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
      .req        (pending_q),
      .last_grant (last_grant_q),
      .any_grant  (arb_any),
      .grant      (arb_grant),
      .grant_idx  (arb_idx)
   );

   always_comb begin
      src_edge     = src_req & ~req_q;
      ack_edge     = ack_sync_q & ~ack_prev_q;
      grant_clr    = '0;
      req_d        = src_req;
      ack_meta_d   = mcu_ack;
      ack_sync_d   = ack_meta_q;
      ack_prev_d   = ack_sync_q;
      state_d      = state_q;
      pulse_cnt_d  = pulse_cnt_q;
      ack_cnt_d    = ack_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      early_ack_d  = early_ack_q;
      last_grant_d = last_grant_q;
      src_id_d     = src_id_q;
      timeout_d    = timeout_q;

      case (state_q)
         IDLE: begin
            if (arb_any) begin
               state_d      = PULSE;
               grant_clr    = arb_grant;
               src_id_d     = arb_idx;
               last_grant_d = arb_idx;
               pulse_cnt_d  = '0;
               early_ack_d  = 1'b0;
            end
         end
         PULSE: begin
            if (ack_edge) begin
               early_ack_d = 1'b1;
            end
            if (pulse_cnt_q == PULSE_LAST) begin
               state_d   = WAIT_ACK;
               ack_cnt_d = '0;
            end else begin
               pulse_cnt_d = pulse_cnt_q + PW'(1);
            end
         end
         WAIT_ACK: begin
            // A real ack always wins over a timeout landing in the same cycle.
            if (ack_edge || early_ack_q) begin
               state_d     = HOLDOFF;
               timeout_d   = 1'b0;
               early_ack_d = 1'b0;
               hold_cnt_d  = '0;
            end else if (ack_cnt_q == ACK_LAST) begin
               state_d    = HOLDOFF;
               timeout_d  = 1'b1;
               hold_cnt_d = '0;
            end else begin
               ack_cnt_d = ack_cnt_q + AW'(1);
            end
         end
         HOLDOFF: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // An edge on the source being granted is kept as a fresh pending event,
      // so it is not counted as an overflow.
      pending_d   = (pending_q & ~grant_clr) | src_edge;
      ovf_d       = (ovf_q & ~ovf_clr) | (src_edge & pending_q & ~grant_clr);
      exti_trig_d = (state_d == PULSE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk25 or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         req_q        <= '0;
         pending_q    <= '0;
         ovf_q        <= '0;
         ack_meta_q   <= 1'b0;
         ack_sync_q   <= 1'b0;
         ack_prev_q   <= 1'b0;
         state_q      <= IDLE;
         pulse_cnt_q  <= '0;
         ack_cnt_q    <= '0;
         hold_cnt_q   <= '0;
         early_ack_q  <= 1'b0;
         last_grant_q <= IDX_W'(NUM_SRC - 1);
         src_id_q     <= '0;
         exti_trig_q  <= 1'b0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         req_q        <= req_d;
         pending_q    <= pending_d;
         ovf_q        <= ovf_d;
         ack_meta_q   <= ack_meta_d;
         ack_sync_q   <= ack_sync_d;
         ack_prev_q   <= ack_prev_d;
         state_q      <= state_d;
         pulse_cnt_q  <= pulse_cnt_d;
         ack_cnt_q    <= ack_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         early_ack_q  <= early_ack_d;
         last_grant_q <= last_grant_d;
         src_id_q     <= src_id_d;
         exti_trig_q  <= exti_trig_d;
         busy_q       <= busy_d;
         timeout_q    <= timeout_d;
      end
   end

   assign exti_trig = exti_trig_q;
   assign src_id    = src_id_q;
   assign busy      = busy_q;
   assign ovf       = ovf_q;
   assign timeout   = timeout_q;

endmodule
